prog_mem_arbiter: RTL and testbench

//   Shares one program-memory read channel among NUM_CONSUMERS fetchers, one per core.

---
 rtl/prog_mem_arbiter.sv | 119 +++++++++++
 tb/tb_prog_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter
//   Shares one read-only program-memory channel among NUM_CONSUMERS fetchers.
//   Round-robin grant, one memory transaction in flight at a time.
//   FSM: IDLE (scan for a request) -> REQ (wait for memory) -> RELEASE (hold
//   response until the owner drops its valid) -> IDLE.
//   All outputs are registered.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   consumer_read_valid      per-fetcher request
//   consumer_read_address    flattened addresses, slice i = [i*ADDR_BITS +: ADDR_BITS]
//   consumer_read_ready      per-fetcher response valid (at most one bit high)
//   consumer_read_data       flattened response data, slice i = [i*DATA_BITS +: DATA_BITS]
//   mem_read_valid/address   request to program memory
//   mem_read_ready/data      response from program memory
//   grant_count              per-consumer 16-bit grant counters (PROG_ARB_STATS_EN only)
//
// Build option
//   PROG_ARB_STATS_EN        adds grant_count port and counters
module prog_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
`ifdef PROG_ARB_STATS_EN
  ,
  output logic [NUM_CONSUMERS*16-1:0]        grant_count
`endif
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick;
  logic          found;

  // (p + k) mod NUM_CONSUMERS without a divider; k < NUM_CONSUMERS and p < NUM_CONSUMERS
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= NUM_CONSUMERS) j = j - NUM_CONSUMERS;
    return IW'(j);
  endfunction

  // First asserted request at or after rr_ptr, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!found && consumer_read_valid[wrap_add(rr_ptr, k)]) begin
        found = 1'b1;
        pick  = wrap_add(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      owner               <= '0;
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
`ifdef PROG_ARB_STATS_EN
      grant_count         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner            <= pick;
            // address is captured here; later address changes do not matter
            mem_read_address <= consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
            mem_read_valid   <= 1'b1;
            state            <= REQ;
`ifdef PROG_ARB_STATS_EN
            grant_count[pick*16 +: 16] <= grant_count[pick*16 +: 16] + 16'd1;
`endif
          end
        end
        REQ: begin
          // completes even if the owner has withdrawn its request meanwhile
          if (mem_read_ready) begin
            mem_read_valid                                  <= 1'b0;
            consumer_read_data[owner*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[owner]                      <= 1'b1;
            state                                           <= RELEASE;
          end
        end
        RELEASE: begin
          if (!consumer_read_valid[owner]) begin
            consumer_read_ready[owner] <= 1'b0;
            // just-served consumer gets lowest priority in the next scan
            rr_ptr <= (owner == IW'(NUM_CONSUMERS - 1)) ? '0 : owner + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
module tb_prog_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // DUT A: two consumers
  logic [1:0]  va = '0;  logic [15:0] aa = '0;
  logic [1:0]  ra;       logic [31:0] da;
  logic        mva;      logic [7:0]  maa;
  logic        mra = 1'b0; logic [15:0] mda = '0;
  // DUT B: three consumers
  logic [2:0]  vb = '0;  logic [23:0] ab = '0;
  logic [2:0]  rb;       logic [47:0] db;
  logic        mvb;      logic [7:0]  mab;
  logic        mrb = 1'b0; logic [15:0] mdb = '0;
`ifdef PROG_ARB_STATS_EN
  logic [31:0] gca;
  logic [47:0] gcb;
`endif

  prog_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(va), .consumer_read_address(aa),
    .consumer_read_ready(ra), .consumer_read_data(da),
    .mem_read_valid(mva), .mem_read_address(maa),
    .mem_read_ready(mra), .mem_read_data(mda)
`ifdef PROG_ARB_STATS_EN
    , .grant_count(gca)
`endif
  );

  prog_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(3)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(vb), .consumer_read_address(ab),
    .consumer_read_ready(rb), .consumer_read_data(db),
    .mem_read_valid(mvb), .mem_read_address(mab),
    .mem_read_ready(mrb), .mem_read_data(mdb)
`ifdef PROG_ARB_STATS_EN
    , .grant_count(gcb)
`endif
  );

  typedef struct { int idx; logic [15:0] data; } exp_t;
  exp_t sba[$];
  exp_t sbb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // memory responder / consumer models
  bit          auto_mem_a = 1'b1, auto_mem_b = 1'b1;
  int          lat_a = 1, lat_b = 1, cnt_a = 0, cnt_b = 0;
  bit          ovr_a = 1'b0;
  logic [15:0] ovr_da = '0;
  bit          auto_cons_a = 1'b0, auto_cons_b = 1'b0;
  int          rem_a [2];
  int          rem_b [3];
  logic [1:0]  pra = '0;
  logic [2:0]  prb = '0;

  function automatic logic [15:0] fn(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  function automatic exp_t mk(input int idx, input logic [15:0] d);
    exp_t e;
    e.idx = idx; e.data = d;
    return e;
  endfunction

  // one cycle: sample at negedge, score rising ready bits, then update models
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) if (ra[i] && !pra[i]) begin
      n_tests++;
      if ($countones(ra) > 1) begin
        n_fail++; $display("FAIL onehot_a ready=%b required at most one bit", ra);
      end else if (sba.size() == 0) begin
        n_fail++; $display("FAIL unexpected_ready_a consumer=%0d required no response", i);
      end else begin
        e = sba.pop_front();
        if (e.idx != i || da[i*16 +: 16] !== e.data) begin
          n_fail++;
          $display("FAIL resp_a got consumer=%0d data=%h required consumer=%0d data=%h",
                   i, da[i*16 +: 16], e.idx, e.data);
        end
      end
    end
    for (int i = 0; i < 3; i++) if (rb[i] && !prb[i]) begin
      n_tests++;
      if ($countones(rb) > 1) begin
        n_fail++; $display("FAIL onehot_b ready=%b required at most one bit", rb);
      end else if (sbb.size() == 0) begin
        n_fail++; $display("FAIL unexpected_ready_b consumer=%0d required no response", i);
      end else begin
        e = sbb.pop_front();
        if (e.idx != i || db[i*16 +: 16] !== e.data) begin
          n_fail++;
          $display("FAIL resp_b got consumer=%0d data=%h required consumer=%0d data=%h",
                   i, db[i*16 +: 16], e.idx, e.data);
        end
      end
    end
    pra = ra; prb = rb;

    if (auto_mem_a) begin
      if (mra) begin mra = 1'b0; cnt_a = 0; end
      else if (mva) begin
        cnt_a++;
        if (cnt_a >= lat_a) begin mra = 1'b1; mda = ovr_a ? ovr_da : fn(maa); end
      end else cnt_a = 0;
    end
    if (auto_mem_b) begin
      if (mrb) begin mrb = 1'b0; cnt_b = 0; end
      else if (mvb) begin
        cnt_b++;
        if (cnt_b >= lat_b) begin mrb = 1'b1; mdb = fn(mab); end
      end else cnt_b = 0;
    end

    // fetcher: drop valid once served, re-request while it has work left
    if (auto_cons_a) for (int i = 0; i < 2; i++) begin
      if (ra[i] && va[i]) va[i] = 1'b0;
      else if (!va[i] && !ra[i] && rem_a[i] > 0) begin va[i] = 1'b1; rem_a[i]--; end
    end
    if (auto_cons_b) for (int i = 0; i < 3; i++) begin
      if (rb[i] && vb[i]) vb[i] = 1'b0;
      else if (!vb[i] && !rb[i] && rem_b[i] > 0) begin vb[i] = 1'b1; rem_b[i]--; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; va = '0; vb = '0; mra = 1'b0; mrb = 1'b0; cnt_a = 0; cnt_b = 0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; va = 2'b11; vb = 3'b111; aa = 16'hFFFF;
    repeat (2) step();
    n_tests++;
    if (ra !== 2'b0 || da !== 32'b0 || mva !== 1'b0 || maa !== 8'b0) begin
      n_fail++; $display("FAIL reset_a ready=%b data=%h mvalid=%b maddr=%h required all 0", ra, da, mva, maa);
    end
    n_tests++;
    if (rb !== 3'b0 || db !== 48'b0 || mvb !== 1'b0 || mab !== 8'b0) begin
      n_fail++; $display("FAIL reset_b ready=%b data=%h mvalid=%b maddr=%h required all 0", rb, db, mvb, mab);
    end
`ifdef PROG_ARB_STATS_EN
    n_tests++;
    if (gca !== 32'b0 || gcb !== 48'b0) begin
      n_fail++; $display("FAIL reset_count got %h %h required 0", gca, gcb);
    end
`endif
    va = '0; vb = '0; aa = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    lat_a = 2; ovr_a = 1'b1; ovr_da = 16'hBEEF;
    aa[7:0] = 8'h12; va = 2'b01;
    sba.push_back(mk(0, 16'hBEEF));
    step();
    n_tests++;
    if (mva !== 1'b1 || maa !== 8'h12) begin
      n_fail++; $display("FAIL grant_latency mvalid=%b maddr=%h required 1 12", mva, maa);
    end
    aa[7:0] = 8'h99;  // must be ignored after grant
    step();
    n_tests++;
    if (maa !== 8'h12) begin
      n_fail++; $display("FAIL addr_latch maddr=%h required 12", maa);
    end
    for (int t = 0; t < 20 && !ra[0]; t++) step();
    repeat (3) step();
    n_tests++;
    if (ra !== 2'b01 || da[15:0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL hold_ready ready=%b data0=%h required 01 beef", ra, da[15:0]);
    end
    va = 2'b00;
    repeat (2) step();
    n_tests++;
    if (ra !== 2'b00 || da[15:0] !== 16'hBEEF || sba.size() != 0) begin
      n_fail++; $display("FAIL release ready=%b data0=%h pending=%0d required 00 beef 0", ra, da[15:0], sba.size());
    end
    ovr_a = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    lat_a = 1; aa = {8'h31, 8'h20};
    rem_a[0] = 2; rem_a[1] = 2;
    sba.push_back(mk(0, fn(8'h20))); sba.push_back(mk(1, fn(8'h31)));
    sba.push_back(mk(0, fn(8'h20))); sba.push_back(mk(1, fn(8'h31)));
    auto_cons_a = 1'b1;
    step();
    for (int t = 0; t < 80 && !(sba.size() == 0 && va == 2'b0 && ra == 2'b0); t++) step();
    auto_cons_a = 1'b0;
    n_tests++;
    if (sba.size() != 0) begin
      n_fail++; $display("FAIL rr_drain pending=%0d required 0", sba.size());
    end
  endtask

  task automatic test_wrap_n3();
    do_reset();
    lat_b = 1; ab = {8'h72, 8'h61, 8'h50};
    rem_b[0] = 0; rem_b[1] = 1; rem_b[2] = 0;
    sbb.push_back(mk(1, fn(8'h61)));
    auto_cons_b = 1'b1;
    step();
    for (int t = 0; t < 40 && !(sbb.size() == 0 && vb == 3'b0 && rb == 3'b0); t++) step();
    // rr_ptr is now 2: c0 wins by wrap, then c1 (rr_ptr 1), then c0
    rem_b[0] = 2; rem_b[1] = 1; rem_b[2] = 0;
    sbb.push_back(mk(0, fn(8'h50))); sbb.push_back(mk(1, fn(8'h61))); sbb.push_back(mk(0, fn(8'h50)));
    step();
    for (int t = 0; t < 80 && !(sbb.size() == 0 && vb == 3'b0 && rb == 3'b0); t++) step();
    auto_cons_b = 1'b0;
    n_tests++;
    if (sbb.size() != 0) begin
      n_fail++; $display("FAIL wrap_drain pending=%0d required 0", sbb.size());
    end
  endtask

  task automatic test_drop_in_req();
    do_reset();
    lat_a = 3; ovr_a = 1'b1; ovr_da = 16'h00AA;
    aa[15:8] = 8'h44; va = 2'b10;
    sba.push_back(mk(1, 16'h00AA));
    step();
    n_tests++;
    if (mva !== 1'b1 || maa !== 8'h44) begin
      n_fail++; $display("FAIL drop_req mvalid=%b maddr=%h required 1 44", mva, maa);
    end
    va = 2'b00;
    for (int t = 0; t < 20 && !ra[1]; t++) step();
    n_tests++;
    if (ra !== 2'b10 || da[31:16] !== 16'h00AA) begin
      n_fail++; $display("FAIL drop_resp ready=%b data1=%h required 10 00aa", ra, da[31:16]);
    end
    step();
    n_tests++;
    if (ra !== 2'b00 || mva !== 1'b0 || sba.size() != 0) begin
      n_fail++; $display("FAIL drop_pulse ready=%b mvalid=%b pending=%0d required 00 0 0", ra, mva, sba.size());
    end
    ovr_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_mem_a = 1'b0;
    aa[7:0] = 8'h2C; va = 2'b01;
    step();
    n_tests++;
    if (mva !== 1'b1 || maa !== 8'h2C) begin
      n_fail++; $display("FAIL mid_req mvalid=%b maddr=%h required 1 2c", mva, maa);
    end
    mra = 1'b1; mda = 16'h1234; reset = 1'b1;
    step();
    n_tests++;
    if (ra !== 2'b0 || da !== 32'b0 || mva !== 1'b0 || maa !== 8'b0) begin
      n_fail++; $display("FAIL mid_reset ready=%b data=%h mvalid=%b maddr=%h required all 0", ra, da, mva, maa);
    end
    reset = 1'b0; mra = 1'b0; va = 2'b00;
    repeat (2) step();
    // memory response while idle must be ignored
    mra = 1'b1; mda = 16'hFFFF;
    step();
    mra = 1'b0;
    repeat (2) step();
    n_tests++;
    if (ra !== 2'b0 || da !== 32'b0 || mva !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore ready=%b data=%h mvalid=%b required 0 0 0", ra, da, mva);
    end
    auto_mem_a = 1'b1;
  endtask

`ifdef PROG_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    lat_a = 1; aa = {8'h07, 8'h03};
    rem_a[0] = 5; rem_a[1] = 3;
    sba.push_back(mk(0, fn(8'h03))); sba.push_back(mk(1, fn(8'h07)));
    sba.push_back(mk(0, fn(8'h03))); sba.push_back(mk(1, fn(8'h07)));
    sba.push_back(mk(0, fn(8'h03))); sba.push_back(mk(1, fn(8'h07)));
    sba.push_back(mk(0, fn(8'h03))); sba.push_back(mk(0, fn(8'h03)));
    auto_cons_a = 1'b1;
    step();
    for (int t = 0; t < 120 && !(sba.size() == 0 && va == 2'b0 && ra == 2'b0); t++) step();
    auto_cons_a = 1'b0;
    n_tests++;
    if (gca !== {16'd3, 16'd5} || sba.size() != 0) begin
      n_fail++; $display("FAIL grant_count got %h pending=%0d required 00030005 0", gca, sba.size());
    end
    do_reset();
    n_tests++;
    if (gca !== 32'b0) begin
      n_fail++; $display("FAIL count_clear got %h required 0", gca);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_wrap_n3();
    test_drop_in_req();
    test_reset_mid();
`ifdef PROG_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
